vec_alu_sequencer: RTL and testbench

Parametrised successor to the combinational opcode-to-ALU-control decoder in the vector ASIP control unit. Accepts one vector instruction opcode per handshake and decodes it to an ALU operation. Sequences the operation over the vector register as VLEN/LANES beats, with valid/ready backpressure toward the vector datapath. DIV beats get a fixed multi-cycle spacing. Sits between instruction fetch/decode and the lane-parallel vector ALU.

---
 rtl/vec_ctrl_pkg.sv | 33 +++
 rtl/alu_op_decoder.sv | 49 ++++
 rtl/vec_alu_sequencer.sv | 130 +++++++++++++
 tb/tb_vec_alu_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_ctrl_pkg.sv
// Shared definitions for the vector control path: ALU operation codes,
// instruction opcodes and the beat-sequencer state encoding.
package vec_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_NOP  = 3'b000,
        ALU_PASS = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_MUL  = 3'b100,
        ALU_DIV  = 3'b101
    } aluop_e;

    localparam logic [3:0] OPC_PASS_0 = 4'b0000;
    localparam logic [3:0] OPC_PASS_1 = 4'b0001;
    localparam logic [3:0] OPC_PASS_4 = 4'b0100;
    localparam logic [3:0] OPC_PASS_C = 4'b1100;
    localparam logic [3:0] OPC_PASS_D = 4'b1101;
    localparam logic [3:0] OPC_PASS_E = 4'b1110;
    localparam logic [3:0] OPC_ADD    = 4'b1000;
    localparam logic [3:0] OPC_SUB    = 4'b1001;
    localparam logic [3:0] OPC_MUL    = 4'b1010;
    localparam logic [3:0] OPC_DIV    = 4'b1011;
    localparam logic [3:0] OPC_CMP_5  = 4'b0101;
    localparam logic [3:0] OPC_CMP_F  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_DIVWAIT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decoder: maps an instruction opcode to the ALU
// control code and whether the result is written back (compares are flags-only).
module alu_op_decoder
    import vec_ctrl_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode_i,
    output aluop_e           aluop_o,
    output logic             wb_en_o
);

    always_comb begin
        aluop_o = ALU_NOP;
        wb_en_o = 1'b0;
        case (opcode_i)
            OPC_W'(OPC_PASS_C), OPC_W'(OPC_PASS_D), OPC_W'(OPC_PASS_E),
            OPC_W'(OPC_PASS_4), OPC_W'(OPC_PASS_0), OPC_W'(OPC_PASS_1): begin
                aluop_o = ALU_PASS;
                wb_en_o = 1'b1;
            end
            OPC_W'(OPC_ADD): begin
                aluop_o = ALU_ADD;
                wb_en_o = 1'b1;
            end
            OPC_W'(OPC_SUB): begin
                aluop_o = ALU_SUB;
                wb_en_o = 1'b1;
            end
            OPC_W'(OPC_MUL): begin
                aluop_o = ALU_MUL;
                wb_en_o = 1'b1;
            end
            OPC_W'(OPC_DIV): begin
                aluop_o = ALU_DIV;
                wb_en_o = 1'b1;
            end
            OPC_W'(OPC_CMP_F), OPC_W'(OPC_CMP_5): begin
                aluop_o = ALU_SUB;
                wb_en_o = 1'b0;
            end
            default: begin
                aluop_o = ALU_NOP;
                wb_en_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: accepts one opcode per handshake and issues it to the
// lane-parallel ALU as VLEN/LANES beats, spacing DIV beats by DIV_LAT cycles.
module vec_alu_sequencer
    import vec_ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int ALUOP_W = 3,
    parameter int VLEN    = 16,
    parameter int LANES   = 4,
    parameter int DIV_LAT = 4,
    parameter int BEAT_W  = ((VLEN / LANES) > 1) ? $clog2(VLEN / LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   in_opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [BEAT_W-1:0]  out_beat,
    output logic               out_last,
    output logic               out_wb_en,
    output logic               busy
);

    localparam int                NBEATS    = VLEN / LANES;
    localparam int                WAIT_W    = $clog2(DIV_LAT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(DIV_LAT - 1);
    localparam bit                DIV_STALL = (DIV_LAT > 1);

    seq_state_e          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    aluop_e              aluop_q, aluop_d;
    logic                wbEn_q, wbEn_d;
    aluop_e              decAluop;
    logic                decWbEn;

    alu_op_decoder #(
        .OPC_W (OPC_W)
    ) u_decoder (
        .opcode_i (in_opcode),
        .aluop_o  (decAluop),
        .wb_en_o  (decWbEn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            aluop_q <= ALU_NOP;
            wbEn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            aluop_q <= aluop_d;
            wbEn_q  <= wbEn_d;
        end
    end

    // The beat index returns to 0 after the last beat so an idle sequencer shows beat 0.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        aluop_d = aluop_q;
        wbEn_d  = wbEn_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    aluop_d = decAluop;
                    wbEn_d  = decWbEn;
                    beat_d  = '0;
                    if (decAluop == ALU_NOP) begin
                        state_d = ST_IDLE;
                    end else if ((decAluop == ALU_DIV) && DIV_STALL) begin
                        state_d = ST_DIVWAIT;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DIVWAIT: begin
                wait_d = wait_q - WAIT_W'(1);
                if (wait_q <= WAIT_W'(1)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        if ((aluop_q == ALU_DIV) && DIV_STALL) begin
                            state_d = ST_DIVWAIT;
                            wait_d  = WAIT_LOAD;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ALU control is gated so the datapath never sees a stale operation between beats.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_ISSUE);
        busy      = (state_q != ST_IDLE);
        out_beat  = beat_q;
        out_last  = 1'b0;
        out_aluop = '0;
        out_wb_en = 1'b0;
        if (state_q == ST_ISSUE) begin
            out_last  = (beat_q == LAST_BEAT);
            out_aluop = ALUOP_W'(aluop_q);
            out_wb_en = wbEn_q;
        end
    end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer: expected beats are queued when an
// opcode is issued and compared as the sequencer hands them to the ALU.
module tb_vec_alu_sequencer;

    localparam int NB = 4;
    localparam int DL = 4;

    typedef struct packed {
        logic [2:0] aluop;
        logic [1:0] beat;
        logic       last;
        logic       wb;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_aluop;
    logic [1:0] out_beat;
    logic       out_last;
    logic       out_wb_en;
    logic       busy;

    int    errors    = 0;
    int    checks    = 0;
    int    cyc       = 0;
    int    acceptCyc = 0;
    beat_t sb[$];
    int    hsQ[$];
    beat_t expBeat;

    vec_alu_sequencer #(
        .OPC_W   (4),
        .ALUOP_W (3),
        .VLEN    (16),
        .LANES   (4),
        .DIV_LAT (DL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_aluop (out_aluop),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .out_wb_en (out_wb_en),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input logic [3:0] opc, output logic [2:0] op, output logic wb);
        case (opc)
            4'b1100, 4'b1101, 4'b1110, 4'b0100, 4'b0000, 4'b0001: begin op = 3'b001; wb = 1'b1; end
            4'b1000: begin op = 3'b010; wb = 1'b1; end
            4'b1001: begin op = 3'b011; wb = 1'b1; end
            4'b1010: begin op = 3'b100; wb = 1'b1; end
            4'b1011: begin op = 3'b101; wb = 1'b1; end
            4'b1111, 4'b0101: begin op = 3'b011; wb = 1'b0; end
            default: begin op = 3'b000; wb = 1'b0; end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one opcode for a single accepting edge and queue the beats it should produce.
    task automatic applyStimulus(input logic [3:0] opc);
        logic [2:0] op;
        logic       wb;
        model(opc, op, wb);
        @(negedge clk);
        checkOutput("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        in_opcode = opc;
        if (op != 3'b000) begin
            for (int i = 0; i < NB; i++) begin
                sb.push_back('{op, 2'(i), (i == NB - 1), wb});
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        acceptCyc = cyc;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(in_ready && sb.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, in_ready, 1);
        checkOutput({tag, "_drained"}, sb.size(), 0);
    endtask

    // Every handshake is matched against the oldest queued beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checkOutput("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                expBeat = sb.pop_front();
                checkOutput("beat_aluop", out_aluop, expBeat.aluop);
                checkOutput("beat_index", out_beat, expBeat.beat);
                checkOutput("beat_last", out_last, expBeat.last);
                checkOutput("beat_wb_en", out_wb_en, expBeat.wb);
                hsQ.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = 4'b0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_aluop", out_aluop, 0);
        checkOutput("rst_out_beat", out_beat, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_wb_en", out_wb_en, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;

        // ADD, with a DIV opcode held on the input while busy that must be ignored
        applyStimulus(4'b1000);
        in_valid  = 1'b1;
        in_opcode = 4'b1011;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            checkOutput("add_valid", out_valid, 1);
            checkOutput("add_beat", out_beat, i);
            checkOutput("add_last", out_last, (i == NB - 1));
            checkOutput("add_in_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("add_ready_after", in_ready, 1);
        checkOutput("add_valid_after", out_valid, 0);
        checkOutput("add_aluop_idle", out_aluop, 0);
        checkOutput("add_wb_idle", out_wb_en, 0);
        waitIdle("add");

        // MUL with beat 1 stalled for three cycles
        applyStimulus(4'b1010);
        @(negedge clk);
        checkOutput("mul_beat0", out_beat, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("mul_stall_valid", out_valid, 1);
            checkOutput("mul_stall_beat", out_beat, 1);
            checkOutput("mul_stall_aluop", out_aluop, 3'b100);
            checkOutput("mul_stall_last", out_last, 0);
            checkOutput("mul_stall_wb", out_wb_en, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitIdle("mul");

        // DIV: beats spaced DIV_LAT cycles apart
        hsQ.delete();
        applyStimulus(4'b1011);
        @(negedge clk);
        checkOutput("div_wait_valid", out_valid, 0);
        checkOutput("div_wait_busy", busy, 1);
        checkOutput("div_wait_aluop", out_aluop, 0);
        waitIdle("div");
        checkOutput("div_beat_count", hsQ.size(), NB);
        for (int k = 0; k < hsQ.size(); k++) begin
            checkOutput("div_spacing", hsQ[k] - acceptCyc, (DL - 1) + DL * k);
        end

        // Compares and PASS
        applyStimulus(4'b1111);
        waitIdle("cmp_f");
        applyStimulus(4'b0101);
        waitIdle("cmp_5");
        applyStimulus(4'b1100);
        waitIdle("pass_c");

        // NOP produces no beats
        applyStimulus(4'b0010);
        repeat (3) begin
            @(negedge clk);
            checkOutput("nop_valid", out_valid, 0);
            checkOutput("nop_in_ready", in_ready, 1);
            checkOutput("nop_busy", busy, 0);
        end

        // Reset during beat 2 of SUB
        applyStimulus(4'b1001);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("sub_pre_rst_beat", out_beat, 2);
        checkOutput("sub_pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_aluop", out_aluop, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_beat", out_beat, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b1000);
        @(negedge clk);
        checkOutput("post_rst_beat0", out_beat, 0);
        checkOutput("post_rst_aluop", out_aluop, 3'b010);
        waitIdle("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
